shift_phase_timer: RTL and testbench
====================================

# shift_phase_timer

Parametrised two-phase shift timer for the miner's job-load path. It sequences the midstate-load and remaining-header-load phases, counting qualified shift strobes in each phase, and pulses a done flag at the end of each phase. Phase lengths, counter width and per-phase gating mode are parameters. It adds restart, abort, phase reporting and optional overrun detection, and sits between the shift-in datapath and the miner controller.

## Interface
- CNT_W, 5, counter width; MID_LEN and REM_LEN must each be in 1..2^CNT_W
- MID_LEN, 8, qualified events in the midstate phase
- REM_LEN, 16, qualified events in the remaining phase
- MID_GATED, 0, 0 = midstate phase counts every clk; 1 = counts only on shift_in_enable
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin (or restart) a load sequence
- abort  in  1  return to IDLE, discarding progress
- shift_in_enable  in  1  one-cycle strobe per shifted word
- phase  out  2  00 IDLE, 01 MID, 10 REM, 11 DONE
- count  out  CNT_W  qualified events seen in the current phase
- busy  out  1  high in MID or REM
- midstate_shifts_done  out  1  one-cycle pulse at MID completion
- remaining_shifts_done  out  1  one-cycle pulse at REM completion
- overrun  out  1  sticky stray-strobe flag (see Configuration)

## Operation
- Priority: rst > abort > start > counting.
- Qualified event: in MID, every cycle if MID_GATED=0, else shift_in_enable; in REM, shift_in_enable only; none in IDLE or DONE.
- IDLE: count=0. start -> MID, count=0.
- MID: qualified event with count<MID_LEN-1 -> count+1. Qualified event with count==MID_LEN-1 -> REM, count=0, midstate_shifts_done=1 for that cycle.
- REM: qualified event with count<REM_LEN-1 -> count+1. Qualified event with count==REM_LEN-1 -> DONE, count=0, remaining_shifts_done=1 for that cycle.
- DONE: holds. start -> MID, count=0. abort -> IDLE.
- start in MID/REM/DONE restarts: MID, count=0, no done pulse, even if the same cycle carries the final qualified event.
- abort in any state -> IDLE, count=0, no pulse. abort with start -> IDLE.
- count never wraps: it resets to 0 on each phase transition before it can reach 2^CNT_W.
- Length 1: the first qualified event completes the phase.
- busy = (phase==01 || phase==10). It is decoded from the registered phase.

## Timing
- All outputs are registered. Reset values: phase=00, count=0, busy=0, midstate_shifts_done=0, remaining_shifts_done=0, overrun=0.
- rst asserted at edge N gives reset values after edge N. An in-flight sequence is discarded.
- start sampled at edge N gives phase=01, count=0 after edge N. The first MID qualified event can be sampled at edge N+1.
- Done pulses are high for exactly the cycle after the completing edge, coincident with the new phase value.
- MID_GATED=0: the first MID_LEN cycles after start complete MID. midstate_shifts_done is visible MID_LEN cycles after the start edge.
- There are no back-to-back phases without a strobe. The REM count starts from the edge after the MID completion.

## Configuration
- SHIFT_PHASE_TIMER_OVERRUN_EN defined: overrun is set when shift_in_enable is sampled high in IDLE or DONE. It stays set until rst, abort or start. If set and clear conditions coincide, clear wins.
- SHIFT_PHASE_TIMER_OVERRUN_EN undefined: no overrun logic is built, and overrun is tied to 0. The port remains, so the interface is identical in both builds.

## Test plan
- Defaults, MID_GATED=0: start pulse, then a shift_in_enable strobe every other cycle -> midstate_shifts_done 8 cycles after start; remaining_shifts_done after the 16th strobe; phase=11, busy=0.
- MID_GATED=1, MID_LEN=3, REM_LEN=2: five strobes with gaps -> count follows 1,2,0(REM),1,0(DONE); pulses after strobes 3 and 5 only.
- Restart: start issued in REM at count=7 -> phase=01, count=0, no remaining_shifts_done. Sequence then completes normally.
- Final strobe in REM together with start -> no pulse, phase=01. Same case with abort -> phase=00, no pulse.
- rst asserted mid-MID with start also high -> all outputs at reset values next cycle. Then MID_LEN=REM_LEN=32, CNT_W=5 runs to DONE with count never exceeding 31.
- With SHIFT_PHASE_TIMER_OVERRUN_EN: a strobe in IDLE sets overrun, which persists through further strobes; start clears it. Without the macro, the same stimulus leaves overrun=0.

Source files
------------

// File: rtl/shift_phase_timer.sv
// rtl/shift_phase_timer.sv - two-phase midstate/remaining shift timer for the job-load path
// Overrun detection is built only when SHIFT_PHASE_TIMER_OVERRUN_EN is defined.
module shift_phase_timer #(
   parameter int CNT_W     = 5,
   parameter int MID_LEN   = 8,
   parameter int REM_LEN   = 16,
   parameter int MID_GATED = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             shift_in_enable,
   output logic [1:0]       phase,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             midstate_shifts_done,
   output logic             remaining_shifts_done,
   output logic             overrun
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MID  = 2'b01,
      S_REM  = 2'b10,
      S_DONE = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] MID_LAST = CNT_W'(MID_LEN - 1);
   localparam logic [CNT_W-1:0] REM_LAST = CNT_W'(REM_LEN - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             mid_done_q, mid_done_d;
   logic             rem_done_q, rem_done_d;
   logic             qual;

   always_comb begin
      qual = 1'b0;
      case (state_q)
         S_MID:   qual = (MID_GATED != 0) ? shift_in_enable : 1'b1;
         S_REM:   qual = shift_in_enable;
         default: qual = 1'b0;
      endcase
   end

   // abort beats start, and both suppress any completion on the same edge
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      mid_done_d = 1'b0;
      rem_done_d = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
         count_d = '0;
      end else if (start) begin
         state_d = S_MID;
         count_d = '0;
      end else if (qual) begin
         if (state_q == S_MID) begin
            if (count_q == MID_LAST) begin
               state_d    = S_REM;
               count_d    = '0;
               mid_done_d = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end else begin
            if (count_q == REM_LAST) begin
               state_d    = S_DONE;
               count_d    = '0;
               rem_done_d = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         mid_done_q <= 1'b0;
         rem_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         mid_done_q <= mid_done_d;
         rem_done_q <= rem_done_d;
      end
   end

   assign phase                 = state_q;
   assign count                 = count_q;
   assign busy                  = (state_q == S_MID) || (state_q == S_REM);
   assign midstate_shifts_done  = mid_done_q;
   assign remaining_shifts_done = rem_done_q;

`ifdef SHIFT_PHASE_TIMER_OVERRUN_EN
   logic overrun_q, overrun_d;

   // a strobe with no phase to absorb it is stray; clearing wins over setting
   always_comb begin
      overrun_d = overrun_q;
      if (abort || start) begin
         overrun_d = 1'b0;
      end else if (shift_in_enable && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= overrun_d;
      end
   end

   assign overrun = overrun_q;
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_shift_phase_timer.sv
// tb/tb_shift_phase_timer.sv - scoreboard bench for shift_phase_timer in three configurations
module tb_shift_phase_timer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, abort, sie;
   logic [1:0] ph   [3];
   logic [4:0] cnt  [3];
   logic       bsy  [3];
   logic       md   [3];
   logic       rd   [3];
   logic       ov   [3];

   shift_phase_timer #(.CNT_W(5), .MID_LEN(8), .REM_LEN(16), .MID_GATED(0)) u0 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .shift_in_enable(sie),
      .phase(ph[0]), .count(cnt[0]), .busy(bsy[0]), .midstate_shifts_done(md[0]),
      .remaining_shifts_done(rd[0]), .overrun(ov[0]));

   shift_phase_timer #(.CNT_W(5), .MID_LEN(3), .REM_LEN(2), .MID_GATED(1)) u1 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .shift_in_enable(sie),
      .phase(ph[1]), .count(cnt[1]), .busy(bsy[1]), .midstate_shifts_done(md[1]),
      .remaining_shifts_done(rd[1]), .overrun(ov[1]));

   shift_phase_timer #(.CNT_W(5), .MID_LEN(32), .REM_LEN(32), .MID_GATED(1)) u2 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .shift_in_enable(sie),
      .phase(ph[2]), .count(cnt[2]), .busy(bsy[2]), .midstate_shifts_done(md[2]),
      .remaining_shifts_done(rd[2]), .overrun(ov[2]));

`ifdef SHIFT_PHASE_TIMER_OVERRUN_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   int mid_len [3] = '{8, 3, 32};
   int rem_len [3] = '{16, 2, 32};
   bit gated   [3] = '{1'b0, 1'b1, 1'b1};

   // reference state: phase number 0..3, events seen so far in this phase, stray flag
   int m_ph  [3] = '{0, 0, 0};
   int m_cnt [3] = '{0, 0, 0};
   bit m_ovr [3] = '{1'b0, 1'b0, 1'b0};

   typedef struct {
      int ph;
      int cnt;
      bit busy;
      bit md;
      bit rd;
      bit ov;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic drive(input bit r, input bit s, input bit a, input bit e);
      exp_t x;
      bit   q;
      int   len;
      @(negedge clk);
      rst   = r;
      start = s;
      abort = a;
      sie   = e;
      for (int d = 0; d < 3; d++) begin
         x.md = 1'b0;
         x.rd = 1'b0;
         q    = (m_ph[d] == 1) ? (gated[d] ? e : 1'b1) : ((m_ph[d] == 2) ? e : 1'b0);
         len  = (m_ph[d] == 1) ? mid_len[d] : rem_len[d];
         if (r) begin
            m_ph[d] = 0; m_cnt[d] = 0; m_ovr[d] = 1'b0;
         end else if (a || s) begin
            m_ph[d] = a ? 0 : 1; m_cnt[d] = 0; m_ovr[d] = 1'b0;
         end else begin
            if (OVR_EN && e && (m_ph[d] == 0 || m_ph[d] == 3)) m_ovr[d] = 1'b1;
            if (q) begin
               m_cnt[d] = m_cnt[d] + 1;
               if (m_cnt[d] == len) begin
                  if (m_ph[d] == 1) x.md = 1'b1;
                  else x.rd = 1'b1;
                  m_ph[d]  = m_ph[d] + 1;
                  m_cnt[d] = 0;
               end
            end
         end
         x.ph   = m_ph[d];
         x.cnt  = m_cnt[d];
         x.busy = (m_ph[d] == 1) || (m_ph[d] == 2);
         x.ov   = m_ovr[d];
         sb.push_back(x);
      end
   endtask

   task automatic chk(input string nm, input int d, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s dut%0d t=%0t got=%0d want=%0d", nm, d, $time, got, want);
      end
   endtask

   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         while (sb.size() >= 3) begin
            for (int d = 0; d < 3; d++) begin
               x = sb.pop_front();
               chk("phase",    d, int'(ph[d]),  x.ph);
               chk("count",    d, int'(cnt[d]), x.cnt);
               chk("busy",     d, int'(bsy[d]), int'(x.busy));
               chk("mid_done", d, int'(md[d]),  int'(x.md));
               chk("rem_done", d, int'(rd[d]),  int'(x.rd));
               chk("overrun",  d, int'(ov[d]),  int'(x.ov));
            end
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; sie = 1'b0;
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      // stray strobes in IDLE, then start clears the flag
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 1);
      drive(0, 1, 0, 0);
      // strobe every other cycle through both phases
      for (int i = 0; i < 60; i++) drive(0, 0, 0, (i % 2) == 0);
      // restart while dut0 sits in REM at count 7
      drive(0, 1, 0, 0);
      for (int i = 0; i < 8; i++) drive(0, 0, 0, 0);
      for (int i = 0; i < 7; i++) drive(0, 0, 0, 1);
      drive(0, 1, 0, 1);
      for (int i = 0; i < 40; i++) drive(0, 0, 0, 1);
      // dut1 final REM strobe coinciding with start, then with abort
      drive(0, 1, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
      drive(0, 1, 0, 1);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
      drive(0, 0, 1, 1);
      drive(0, 1, 1, 0);
      // reset in the middle of MID with start also asserted
      drive(0, 1, 0, 0);
      drive(0, 0, 0, 1);
      drive(1, 1, 0, 1);
      drive(0, 0, 0, 0);
      // full-width run on dut2
      drive(0, 1, 0, 0);
      for (int i = 0; i < 70; i++) drive(0, 0, 0, 1);
      for (int i = 0; i < 3000; i++)
         drive($urandom_range(0, 499) == 0, $urandom_range(0, 149) == 0,
               $urandom_range(0, 299) == 0, $urandom_range(0, 9) < 6);
      drive(0, 0, 0, 0);
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
